// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Purpose : Fetches 16-bit instructions, presents them one at a time to the
//           decoder, owns the PC and applies jump redirects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_ack_i,
    input  logic        stall_i,
    input  logic        pc_jump_i,
    input  logic [7:0]  jump_target_i,
    output logic [15:0] instr_out_o,
    output logic        instr_valid_o,
    output logic [7:0]  instr_pc_o,
    output logic        halted_o,
    output logic [15:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  instr_pc_q, instr_pc_d;
    logic [15:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            instr_pc_q <= 8'h00;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d    = imem_rdata_i;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 8'd1;
                    state_d    = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall_i) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    // Halt outranks a jump requested on the same consume edge
                    if (instr_q[15:12] == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else begin
                        if (pc_jump_i) begin
                            pc_d = jump_target_i;
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The request is masked while reset is held so memory sees no fetch until release
    assign imem_req_o    = (state_q == S_FETCH) && rst_n;
    assign imem_addr_o   = pc_q;
    assign instr_out_o   = instr_q;
    assign instr_valid_o = (state_q == S_VALID);
    assign instr_pc_o    = instr_pc_q;
    assign halted_o      = (state_q == S_HALT);
    assign fetch_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module  : tb_instr_fetch_unit
// Purpose : Directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        pc_jump;
    logic [7:0]  jump_target;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [7:0]  instr_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:255];
    logic        req_seen [0:255];
    int          ack_delay;
    int          wait_cnt;

    instr_fetch_unit #(
        .RESET_PC    (8'h00),
        .HALT_OPCODE (4'b1111)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .imem_ack_i    (imem_ack),
        .stall_i       (stall),
        .pc_jump_i     (pc_jump),
        .jump_target_i (jump_target),
        .instr_out_o   (instr_out),
        .instr_valid_o (instr_valid),
        .instr_pc_o    (instr_pc),
        .halted_o      (halted),
        .fetch_count_o (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay waiting cycles of a held request
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (imem_req) req_seen[imem_addr] <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 16'h0000;
            req_seen[i] = 1'b0;
        end
        mem[8'h00] = 16'h4800;
        mem[8'h01] = 16'h0D00;
        mem[8'h02] = 16'h2700;
        mem[8'h03] = 16'hD800;
        mem[8'h04] = 16'h80FF;
        mem[8'h05] = 16'h8004;
        mem[8'hFF] = 16'h1200;
        mem[8'h10] = 16'hF000;
        mem[8'h23] = 16'h5555;
        wait_cnt    = 0;
        ack_delay   = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        pc_jump     = 1'b0;
        jump_target = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_halt",  {31'b0, halted},      32'h0);
        chk("rst_instr", {16'b0, instr_out},   32'h0);
        chk("rst_count", {16'b0, fetch_count}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req",  {31'b0, imem_req},  32'h1);
        chk("rel_addr", {24'b0, imem_addr}, 32'h00);

        // Sequential fetch with 0-wait memory
        tick();
        chk("seq0_valid", {31'b0, instr_valid}, 32'h1);
        chk("seq0_instr", {16'b0, instr_out},   32'h4800);
        chk("seq0_pc",    {24'b0, instr_pc},    32'h00);
        chk("seq0_req",   {31'b0, imem_req},    32'h0);
        tick();
        chk("seq1_addr", {24'b0, imem_addr}, 32'h01);
        tick();
        chk("seq1_instr", {16'b0, instr_out}, 32'h0D00);
        chk("seq1_pc",    {24'b0, instr_pc},  32'h01);
        tick();
        chk("seq2_addr", {24'b0, imem_addr}, 32'h02);
        tick();
        chk("seq2_instr", {16'b0, instr_out}, 32'h2700);
        chk("seq2_pc",    {24'b0, instr_pc},  32'h02);
        tick();
        chk("seq_count", {16'b0, fetch_count}, 32'd3);
        chk("seq3_addr", {24'b0, imem_addr},   32'h03);

        // Stall on D800 for five edges
        stall = 1'b1;
        tick();
        chk("stl_instr", {16'b0, instr_out}, 32'hD800);
        for (int i = 0; i < 5; i++) begin
            tick();
            ok = (instr_out == 16'hD800) && (instr_pc == 8'h03) && instr_valid
                 && !imem_req && (fetch_count == 16'd3);
            chk("stl_hold", {31'b0, ok}, 32'h1);
        end
        ack_delay = 3;
        stall     = 1'b0;
        tick();
        chk("stl_count", {16'b0, fetch_count}, 32'd4);
        chk("stl_addr",  {24'b0, imem_addr},   32'h04);

        // Three wait states: request held for four cycles in total
        for (int i = 0; i < 3; i++) begin
            tick();
            ok = imem_req && (imem_addr == 8'h04) && !instr_valid;
            chk("ws_hold", {31'b0, ok}, 32'h1);
        end
        tick();
        chk("ws_valid", {31'b0, instr_valid}, 32'h1);
        chk("ws_instr", {16'b0, instr_out},   32'h80FF);
        ack_delay = 0;
        tick();
        chk("j_addr5", {24'b0, imem_addr}, 32'h05);
        tick();
        chk("j_instr", {16'b0, instr_out}, 32'h8004);
        pc_jump     = 1'b1;
        jump_target = 8'h04;
        tick();
        chk("j_addr", {24'b0, imem_addr}, 32'h04);
        chk("j_req",  {31'b0, imem_req},  32'h1);
        pc_jump = 1'b0;
        tick();
        chk("j_ipc",    {24'b0, instr_pc},    32'h04);
        chk("j_no6",    {31'b0, req_seen[6]}, 32'h0);

        // Jump to FF, then wrap to 00
        pc_jump     = 1'b1;
        jump_target = 8'hFF;
        tick();
        chk("w_addrff", {24'b0, imem_addr}, 32'hFF);
        pc_jump = 1'b0;
        tick();
        chk("w_ipc", {24'b0, instr_pc}, 32'hFF);
        tick();
        chk("w_addr00", {24'b0, imem_addr}, 32'h00);
        chk("w_req",    {31'b0, imem_req},  32'h1);
        tick();
        pc_jump     = 1'b1;
        jump_target = 8'h10;
        tick();
        chk("h_addr", {24'b0, imem_addr}, 32'h10);
        pc_jump = 1'b0;
        tick();
        chk("h_instr", {16'b0, instr_out}, 32'hF000);
        pc_jump     = 1'b1;
        jump_target = 8'h20;
        tick();
        chk("h_halted", {31'b0, halted},      32'h1);
        chk("h_valid",  {31'b0, instr_valid}, 32'h0);
        chk("h_count",  {16'b0, fetch_count}, 32'd10);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req || !halted || instr_out != 16'hF000 || fetch_count != 16'd10) ok = 1'b0;
        end
        chk("h_stay", {31'b0, ok}, 32'h1);
        pc_jump = 1'b0;

        // Reset out of HALT, then jump to 23 and abort a slow fetch with async reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("r2_addr", {24'b0, imem_addr}, 32'h00);
        tick();
        chk("r2_instr", {16'b0, instr_out}, 32'h4800);
        pc_jump     = 1'b1;
        jump_target = 8'h23;
        ack_delay   = 100;
        tick();
        chk("r2_addr23", {24'b0, imem_addr},   32'h23);
        chk("r2_count",  {16'b0, fetch_count}, 32'd1);
        pc_jump = 1'b0;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   {31'b0, imem_req},    32'h0);
        chk("ar_addr",  {24'b0, imem_addr},   32'h00);
        chk("ar_count", {16'b0, fetch_count}, 32'h0);
        chk("ar_instr", {16'b0, instr_out},   32'h0);
        ack_delay = 0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_rel_req",  {31'b0, imem_req},  32'h1);
        chk("ar_rel_addr", {24'b0, imem_addr}, 32'h00);
        tick();
        chk("ar_fetch", {16'b0, instr_out}, 32'h4800);
        chk("ar_ipc",   {24'b0, instr_pc},  32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the control unit: fetches 16-bit instructions from instruction memory and presents one instruction at a time to the decoder.
- Owns the 8-bit program counter (PC) and applies jump redirects that the control unit produces.
- Stops fetching on a halt opcode; only reset restarts it.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OPCODE, 4'b1111, value of instr[15:12] that halts fetching.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  8  fetch address; equals PC while imem_req=1.
- imem_rdata  input  16  instruction word; valid when imem_ack=1.
- imem_ack  input  1  memory response; may arrive 0..N cycles after the request.
- stall  input  1  downstream not ready; holds the current instruction.
- pc_jump  input  1  jump request from the control unit for the presented instruction.
- jump_target  input  8  jump destination, equal to instr[7:0] of the jump instruction.
- instr_out  output  16  instruction presented to the control unit.
- instr_valid  output  1  instr_out is valid.
- instr_pc  output  8  address instr_out was fetched from.
- halted  output  1  fetch stopped on the halt opcode.
- fetch_count  output  16  count of consumed instructions; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, any state): pc=RESET_PC, state=FETCH, instr_out=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
  - imem_req is 0 while rst_n=0 and is 1 on the first cycle after deassertion.
  - An in-flight fetch is abandoned; a late imem_ack arriving after reset is accepted only as a response to the new request.
- States: FETCH, VALID, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On a clk edge with imem_ack=1: instr_out<=imem_rdata, instr_pc<=pc, pc<=pc+1 (8-bit wrap, 8'hFF -> 8'h00), go to VALID.
  - pc_jump and stall are ignored in FETCH.
- VALID:
  - imem_req=0, instr_valid=1; instr_out and instr_pc are held stable.
  - Consume = clk edge with stall=0. On consume, fetch_count increments, saturating.
  - Consume with instr_out[15:12]==HALT_OPCODE: go to HALT (takes priority over pc_jump).
  - Otherwise consume with pc_jump=1: pc<=jump_target, go to FETCH.
  - Otherwise consume: go to FETCH with the already-incremented pc.
  - stall=1: remain in VALID; pc_jump is not acted on until the consume edge.
- HALT:
  - imem_req=0, instr_valid=0, halted=1; instr_out keeps the halt word.
  - Exit only through reset.
- imem_ack outside FETCH is ignored.
- Latency: with a 0-wait memory (ack in the request cycle), instr_valid rises 1 cycle after the request. With stall=0 throughout, sustained throughput is 1 instruction per 2 cycles.
- A jump to the current pc (self-loop) is legal and refetches the same address.

Test Plan:
- Reset and sequential fetch: release rst_n; 0-wait memory returns 16'h4800, 16'h0D00, 16'h2700 at addresses 0, 1, 2 -> instr_pc = 0, 1, 2, each with instr_valid pulses; imem_addr sequence is 0, 1, 2; fetch_count=3.
- Wait states: imem_ack delayed 3 cycles -> imem_req and imem_addr held constant for 4 cycles, instr_valid=0 until ack, then instr_out=imem_rdata.
- Jump: at pc 5, instr 16'h8004 with pc_jump=1 and jump_target=8'h04 -> next imem_addr=8'h04 and instr_pc=8'h04; address 6 is never requested.
- Stall: hold stall=1 for 5 cycles on 16'hD800 -> instr_out, instr_pc and instr_valid unchanged, no imem_req, fetch_count unchanged; first stall=0 edge consumes it.
- Wrap and halt: fetch at 8'hFF -> next address 8'h00. Then instr 16'hF000 consumed -> halted=1, imem_req=0 for 20 cycles, pc_jump ignored.
- Async reset mid-fetch: drop rst_n while waiting for ack with pc=8'h23 -> outputs reset immediately without a clock edge. After release, imem_addr=RESET_PC and fetch_count=0.
